// File: rtl/pipe_fetch.sv
// IF stage and IF/ID register: PC, variable-latency instruction fetch, stall and redirect handling.
// Optional FETCH_SQUASH_EN: a redirect discards the in-flight or held fetch instead of executing it.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid,
  output logic        fetch_err
);

  // state | meaning
  // REQ   | request outstanding at pc, waiting for ack
  // HOLD  | word fetched during an ID stall, parked in hold_word
  localparam logic S_REQ  = 1'b0;
  localparam logic S_HOLD = 1'b1;
  localparam int   CW     = $clog2(TIMEOUT + 1);

  logic          state;
  logic          pend_v;
  logic [31:0]   pend_pc;
  logic [31:0]   hold_word;
  logic [CW-1:0] wait_cnt;

  logic [31:0] pc_plus4;
  logic [31:0] sel_pc;
  logic [31:0] next_pc;
  logic [31:0] fetched;
  logic        redirect;
  logic        advance;
  logic        squash;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    sel_pc   = pc_plus4;
    case (pcsource)
      2'b01:   sel_pc = bpc;
      2'b10:   sel_pc = da;
      2'b11:   sel_pc = jpc;
      default: sel_pc = pc_plus4;
    endcase
    redirect = !wpcir && (pcsource != 2'b00);
    advance  = !wpcir && ((state == S_HOLD) || imem_ack);
    next_pc  = pend_v ? pend_pc : (wpcir ? pc_plus4 : sel_pc);
    fetched  = (state == S_REQ) ? imem_rdata : hold_word;
`ifdef FETCH_SQUASH_EN
    squash   = pend_v || redirect;
`else
    squash   = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      dpc4      <= 32'd0;
      inst      <= NOP_INST;
      dvalid    <= 1'b0;
      fetch_err <= 1'b0;
      pend_v    <= 1'b0;
      pend_pc   <= 32'd0;
      hold_word <= 32'd0;
      wait_cnt  <= '0;
    end else begin
      if (advance) begin
        state  <= S_REQ;
        pc     <= next_pc;
        pend_v <= 1'b0;
        if (squash) begin
          inst   <= NOP_INST;
          dvalid <= 1'b0;
        end else begin
          dpc4   <= pc_plus4;
          inst   <= fetched;
          dvalid <= 1'b1;
        end
      end else begin
        // target must survive until the delay-slot fetch completes
        if (redirect) begin
          pend_v  <= 1'b1;
          pend_pc <= sel_pc;
        end
        if (state == S_REQ) begin
          if (imem_ack) begin
            hold_word <= imem_rdata;
            state     <= S_HOLD;
          end else if (!wpcir) begin
            inst   <= NOP_INST;
            dvalid <= 1'b0;
          end
        end
      end

      if (state == S_REQ) begin
        if (imem_ack) begin
          wait_cnt <= '0;
        end else begin
          if (wait_cnt != CW'(TIMEOUT)) wait_cnt <= wait_cnt + CW'(1);
          if (wait_cnt >= CW'(TIMEOUT - 1)) fetch_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: vector table for the fetch stream plus hand sequences
// for timeout, reset, held-word stall and PC wrap.
module tb_pipe_fetch;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid, fetch_err;

  int checks = 0;
  int errors = 0;

  pipe_fetch #(.RESET_PC(32'h0), .NOP_INST(32'h0), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .da(da), .jpc(jpc),
    .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid),
    .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, ack, wp;
    logic [1:0]  ps;
    logic [31:0] rdata;
    logic        chk;
    logic [31:0] e_addr;
    logic        e_req;
    logic [31:0] e_dpc4, e_inst;
    logic        e_dv;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(logic rst, logic ack, logic wp, logic [1:0] ps, logic [31:0] rdata,
                               logic chk, logic [31:0] e_addr, logic e_req, logic [31:0] e_dpc4,
                               logic [31:0] e_inst, logic e_dv);
    vec_t v;
    v.rst = rst; v.ack = ack; v.wp = wp; v.ps = ps; v.rdata = rdata; v.chk = chk;
    v.e_addr = e_addr; v.e_req = e_req; v.e_dpc4 = e_dpc4; v.e_inst = e_inst; v.e_dv = e_dv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic ack, logic wp, logic [1:0] ps, logic [31:0] rdata);
    @(negedge clock);
    reset = rst; imem_ack = ack; wpcir = wp; pcsource = ps; imem_rdata = rdata;
    #1;
  endtask

  initial begin
    logic [31:0] sq_dpc4_14, sq_inst_14, sq_dpc4_16, sq_inst_16, sq_dpc4_18, sq_inst_18;
    logic        sq_dv;
`ifdef FETCH_SQUASH_EN
    sq_dv = 1'b0;
    sq_dpc4_14 = 32'h14;  sq_inst_14 = 32'h0;
    sq_dpc4_16 = 32'h44;  sq_inst_16 = 32'h0;
    sq_dpc4_18 = 32'h104; sq_inst_18 = 32'h0;
`else
    sq_dv = 1'b1;
    sq_dpc4_14 = 32'h18;  sq_inst_14 = 32'hA000_0014;
    sq_dpc4_16 = 32'h48;  sq_inst_16 = 32'hA000_0044;
    sq_dpc4_18 = 32'h108; sq_inst_18 = 32'hA000_0104;
`endif
    bpc = 32'h40; da = 32'h100; jpc = 32'h200;
    reset = 1'b1; imem_ack = 1'b0; wpcir = 1'b0; pcsource = 2'b00; imem_rdata = 32'h0;

    //          rst   ack   wp    ps     rdata          chk  addr     req   dpc4        inst         dv
    vt.push_back(row(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,   1'b1, 32'h0,      32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_0000, 1'b1, 32'h0,   1'b1, 32'h0,      32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_0004, 1'b1, 32'h4,   1'b1, 32'h4,      32'hA000_0000, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h8,   1'b1, 32'h8,      32'hA000_0004, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h8,   1'b1, 32'h8,      32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h8,   1'b1, 32'h8,      32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_0008, 1'b1, 32'h8,   1'b1, 32'h8,      32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_000C, 1'b1, 32'hC,   1'b1, 32'hC,      32'hA000_0008, 1'b1));
    vt.push_back(row(1'b0, 1'b1, 1'b1, 2'b00, 32'hA000_0010, 1'b1, 32'h10,  1'b1, 32'h10,     32'hA000_000C, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,        1'b1, 32'h10,  1'b0, 32'h10,     32'hA000_000C, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h10,  1'b0, 32'h10,     32'hA000_000C, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b01, 32'h0,        1'b1, 32'h14,  1'b1, 32'h14,     32'hA000_0010, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h14,  1'b1, 32'h14,     32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_0014, 1'b1, 32'h14,  1'b1, 32'h14,     32'h0,       1'b0));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_0040, 1'b1, 32'h40,  1'b1, sq_dpc4_14, sq_inst_14,  sq_dv));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b10, 32'hA000_0044, 1'b1, 32'h44,  1'b1, 32'h44,     32'hA000_0040, 1'b1));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b00, 32'hA000_0100, 1'b1, 32'h100, 1'b1, sq_dpc4_16, sq_inst_16,  sq_dv));
    vt.push_back(row(1'b0, 1'b1, 1'b0, 2'b11, 32'hA000_0104, 1'b1, 32'h104, 1'b1, 32'h104,    32'hA000_0100, 1'b1));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h200, 1'b1, sq_dpc4_18, sq_inst_18,  sq_dv));
    vt.push_back(row(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h200, 1'b1, sq_dpc4_18, 32'h0,       1'b0));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].ack, vt[i].wp, vt[i].ps, vt[i].rdata);
      if (vt[i].chk) begin
        chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].e_addr);
        chk($sformatf("v%0d pc", i), pc, vt[i].e_addr);
        chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vt[i].e_req});
        chk($sformatf("v%0d dpc4", i), dpc4, vt[i].e_dpc4);
        chk($sformatf("v%0d inst", i), inst, vt[i].e_inst);
        chk($sformatf("v%0d dvalid", i), {31'd0, dvalid}, {31'd0, vt[i].e_dv});
        chk($sformatf("v%0d fetch_err", i), {31'd0, fetch_err}, 32'd0);
      end
    end

    // reset while a request is outstanding at 0x200, then starve ack to hit the timeout
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    for (int i = 0; i < TO; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      if (i == 0) begin
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst imem_req", {31'd0, imem_req}, 32'd1);
        chk("rst dvalid", {31'd0, dvalid}, 32'd0);
      end
      chk($sformatf("to%0d fetch_err", i), {31'd0, fetch_err}, 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'hB000_0000);
    chk("timeout fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("timeout imem_req", {31'd0, imem_req}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("sticky fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("late inst", inst, 32'hB000_0000);
    chk("late dpc4", dpc4, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);

    // stall with ack: pcsource asserted during the stall must be ignored
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'hC000_0000);
    chk("clr fetch_err", {31'd0, fetch_err}, 32'd0);
    jpc = 32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
    chk("hold imem_req", {31'd0, imem_req}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("hold release req", {31'd0, imem_req}, 32'd0);
    chk("hold inst kept", inst, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 2'b11, 32'hC000_0004);
    chk("hold inst", inst, 32'hC000_0000);
    chk("hold pc", pc, 32'h4);

    // jump to the top word; the fetch after it wraps to zero
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'hD000_0000);
    chk("wrap pc", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("wrap dpc4", dpc4, 32'h0);
    chk("wrap imem_addr", imem_addr, 32'h0);
    chk("wrap inst", inst, 32'hD000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
